// File: rtl/fp_csr_ctrl.sv
// Floating-point CSR controller: fflags/frm/fcsr access, FPU flag accrual and rounding-mode resolution.
// Optional FS dirty tracking is enabled by defining FP_CSR_FS_DIRTY_EN.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | ready for a CSR instruction
//   S_WAIT | instruction captured, held until the FPU drains, then commits
//   S_RESP | one-cycle response strobe with old value and illegal flag
module fp_csr_ctrl #(
    parameter int         NUM_FLAG_PORTS = 2,
    parameter logic [2:0] RESET_FRM      = 3'b000
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        csr_valid_i,
    output logic                        csr_ready_o,
    input  logic [31:0]                 csr_instr_i,
    input  logic [31:0]                 csr_rs1_i,
    output logic                        csr_rvalid_o,
    output logic [31:0]                 csr_rdata_o,
    output logic                        csr_illegal_o,
    input  logic                        fpu_busy_i,
    input  logic [NUM_FLAG_PORTS-1:0]   fpu_flag_valid_i,
    input  logic [5*NUM_FLAG_PORTS-1:0] fpu_flags_i,
    input  logic [2:0]                  instr_rm_i,
    output logic [2:0]                  frm_o,
    output logic                        rm_illegal_o,
    output logic [4:0]                  fflags_q_o,
    output logic [2:0]                  frm_q_o
`ifdef FP_CSR_FS_DIRTY_EN
    ,
    input  logic                        fs_clean_i,
    output logic                        fs_dirty_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [4:0]  fflags_q;
    logic [2:0]  frm_q;

    logic [11:0] addr_q;
    logic [4:0]  uimm_q;
    logic [2:0]  funct3_q;
    logic [6:0]  opcode_q;
    logic [7:0]  rs1_q;

    logic [4:0]  accrued;
    logic [7:0]  operand;
    logic [7:0]  cur_val;
    logic [7:0]  old_val;
    logic [7:0]  wr_mask;
    logic [7:0]  wr_bits;
    logic [7:0]  new_val;
    logic        legal_op;
    logic        legal_addr;
    logic        illegal;
    logic        do_write;
    logic        commit;

    // Only the low byte of rs1 can reach any of the three CSRs; rd is not needed here.
    logic unused_bits;
    assign unused_bits = ^{csr_rs1_i[31:8], csr_instr_i[11:7]};

    always_comb begin
        accrued = '0;
        for (int k = 0; k < NUM_FLAG_PORTS; k++) begin
            if (fpu_flag_valid_i[k]) begin
                accrued = accrued | fpu_flags_i[5*k +: 5];
            end
        end
    end

    always_comb begin
        operand    = funct3_q[2] ? {3'b000, uimm_q} : rs1_q;
        cur_val    = {frm_q, fflags_q};
        legal_op   = (opcode_q == 7'h73) && (funct3_q[1:0] != 2'b00);
        legal_addr = 1'b1;
        wr_mask    = 8'h00;
        wr_bits    = 8'h00;
        old_val    = 8'h00;
        case (addr_q)
            12'h001: begin
                wr_mask = 8'h1F;
                wr_bits = {3'b000, operand[4:0]};
                old_val = {3'b000, fflags_q};
            end
            12'h002: begin
                wr_mask = 8'hE0;
                wr_bits = {operand[2:0], 5'b00000};
                old_val = {5'b00000, frm_q};
            end
            12'h003: begin
                wr_mask = 8'hFF;
                wr_bits = operand;
                old_val = cur_val;
            end
            default: legal_addr = 1'b0;
        endcase

        illegal  = !(legal_op && legal_addr);
        // Set/clear forms with a zero rs1/uimm field are pure reads.
        do_write = !illegal && ((funct3_q[1:0] == 2'b01) || (uimm_q != 5'd0));

        case (funct3_q[1:0])
            2'b01:   new_val = (cur_val & ~wr_mask) | wr_bits;
            2'b10:   new_val = cur_val | wr_bits;
            2'b11:   new_val = cur_val & ~wr_bits;
            default: new_val = cur_val;
        endcase

        commit = (state == S_WAIT) && !fpu_busy_i;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= S_IDLE;
            fflags_q      <= 5'd0;
            frm_q         <= RESET_FRM;
            csr_ready_o   <= 1'b1;
            csr_rvalid_o  <= 1'b0;
            csr_rdata_o   <= 32'd0;
            csr_illegal_o <= 1'b0;
            addr_q        <= 12'd0;
            uimm_q        <= 5'd0;
            funct3_q      <= 3'd0;
            opcode_q      <= 7'd0;
            rs1_q         <= 8'd0;
        end else begin
            fflags_q <= fflags_q | accrued;
            case (state)
                S_IDLE: begin
                    if (csr_valid_i) begin
                        addr_q      <= csr_instr_i[31:20];
                        uimm_q      <= csr_instr_i[19:15];
                        funct3_q    <= csr_instr_i[14:12];
                        opcode_q    <= csr_instr_i[6:0];
                        rs1_q       <= csr_rs1_i[7:0];
                        csr_ready_o <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (commit) begin
                        if (do_write) begin
                            // Flags raised on the commit edge must survive the write.
                            fflags_q <= new_val[4:0] | accrued;
                            frm_q    <= new_val[7:5];
                        end
                        csr_rdata_o   <= illegal ? 32'd0 : {24'd0, old_val};
                        csr_illegal_o <= illegal;
                        csr_rvalid_o  <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    csr_rvalid_o  <= 1'b0;
                    csr_rdata_o   <= 32'd0;
                    csr_illegal_o <= 1'b0;
                    csr_ready_o   <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    csr_rvalid_o  <= 1'b0;
                    csr_rdata_o   <= 32'd0;
                    csr_illegal_o <= 1'b0;
                    csr_ready_o   <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FP_CSR_FS_DIRTY_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            fs_dirty_o <= 1'b0;
        end else if ((accrued != 5'd0) || (commit && do_write)) begin
            fs_dirty_o <= 1'b1;
        end else if (fs_clean_i) begin
            fs_dirty_o <= 1'b0;
        end
    end
`endif

    assign frm_o        = (instr_rm_i == 3'b111) ? frm_q : instr_rm_i;
    assign rm_illegal_o = (frm_o == 3'b101) || (frm_o == 3'b110) || (frm_o == 3'b111);
    assign fflags_q_o   = fflags_q;
    assign frm_q_o      = frm_q;

endmodule

// File: tb/tb_fp_csr_ctrl.sv
// Self-checking bench for fp_csr_ctrl: scoreboard of expected responses plus per-feature tasks.
module tb_fp_csr_ctrl;

    localparam int         NP  = 2;
    localparam logic [2:0] RFRM = 3'b011;

    logic          clk;
    logic          rst_l;
    logic          csr_valid;
    logic          csr_ready_o;
    logic [31:0]   csr_instr;
    logic [31:0]   csr_rs1;
    logic          csr_rvalid_o;
    logic [31:0]   csr_rdata_o;
    logic          csr_illegal_o;
    logic          fpu_busy;
    logic [NP-1:0] flag_valid;
    logic [5*NP-1:0] flags;
    logic [2:0]    instr_rm;
    logic [2:0]    frm_o;
    logic          rm_illegal_o;
    logic [4:0]    fflags_q_o;
    logic [2:0]    frm_q_o;
`ifdef FP_CSR_FS_DIRTY_EN
    logic          fs_clean;
    logic          fs_dirty_o;
`endif

    fp_csr_ctrl #(.NUM_FLAG_PORTS(NP), .RESET_FRM(RFRM)) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .csr_valid_i      (csr_valid),
        .csr_ready_o      (csr_ready_o),
        .csr_instr_i      (csr_instr),
        .csr_rs1_i        (csr_rs1),
        .csr_rvalid_o     (csr_rvalid_o),
        .csr_rdata_o      (csr_rdata_o),
        .csr_illegal_o    (csr_illegal_o),
        .fpu_busy_i       (fpu_busy),
        .fpu_flag_valid_i (flag_valid),
        .fpu_flags_i      (flags),
        .instr_rm_i       (instr_rm),
        .frm_o            (frm_o),
        .rm_illegal_o     (rm_illegal_o),
        .fflags_q_o       (fflags_q_o),
        .frm_q_o          (frm_q_o)
`ifdef FP_CSR_FS_DIRTY_EN
        ,
        .fs_clean_i       (fs_clean),
        .fs_dirty_o       (fs_dirty_o)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        int          lat;
        int          acc;
    } resp_t;

    resp_t sb[$];
    resp_t mon_e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic  prev_rv  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_l) begin
            if (csr_rvalid_o) begin
                n_checks++;
                if (prev_rv) begin
                    n_fail++;
                    $display("FAIL rvalid_width: rvalid high on consecutive cycles, required single pulse");
                end
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid: rdata=%h illegal=%b with no pending instruction", csr_rdata_o, csr_illegal_o);
                end else begin
                    mon_e = sb.pop_front();
                    n_checks += 3;
                    if (csr_rdata_o !== mon_e.rdata) begin
                        n_fail++;
                        $display("FAIL resp_rdata: got %h required %h", csr_rdata_o, mon_e.rdata);
                    end
                    if (csr_illegal_o !== mon_e.ill) begin
                        n_fail++;
                        $display("FAIL resp_illegal: got %b required %b", csr_illegal_o, mon_e.ill);
                    end
                    if ((cyc - mon_e.acc) != mon_e.lat) begin
                        n_fail++;
                        $display("FAIL resp_latency: got %0d required %0d", cyc - mon_e.acc, mon_e.lat);
                    end
                end
            end else begin
                n_checks++;
                if (csr_rdata_o !== 32'd0 || csr_illegal_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs: rdata=%h illegal=%b required 0/0", csr_rdata_o, csr_illegal_o);
                end
            end
        end
        prev_rv = csr_rvalid_o;
    end

    function automatic logic [31:0] mk(input logic [11:0] addr, input logic [4:0] rs1f,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {addr, rs1f, f3, 5'd1, opc};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs1,
                         input logic [31:0] er, input logic ei, input int el);
        int    w;
        resp_t e;
        csr_instr = instr;
        csr_rs1   = rs1;
        csr_valid = 1'b1;
        w = 0;
        while (csr_ready_o !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (csr_ready_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: ready=%b required 1 within 100 cycles", csr_ready_o);
            csr_valid = 1'b0;
            return;
        end
        e.rdata = er;
        e.ill   = ei;
        e.lat   = el;
        e.acc   = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        csr_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL resp_timeout: %0d responses pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_regs(input string name, input logic [4:0] ef, input logic [2:0] em);
        n_checks += 2;
        if (fflags_q_o !== ef) begin
            n_fail++;
            $display("FAIL %s_fflags: got %h required %h", name, fflags_q_o, ef);
        end
        if (frm_q_o !== em) begin
            n_fail++;
            $display("FAIL %s_frm: got %b required %b", name, frm_q_o, em);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (csr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", csr_ready_o); end
        if (csr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b required 0", csr_rvalid_o); end
        if (csr_rdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", csr_rdata_o); end
        if (csr_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b required 0", csr_illegal_o); end
        check_regs("reset", 5'h00, RFRM);
        rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_x0();
        issue(mk(12'h003, 5'd0, 3'b010, 7'h73), 32'h0000_00FF, 32'h0000_0060, 1'b0, 2);
        wait_resp();
        check_regs("read_x0", 5'h00, RFRM);
    endtask

    task automatic test_write_fcsr();
        issue(mk(12'h003, 5'd7, 3'b001, 7'h73), 32'hFFFF_FF5A, 32'h0000_0060, 1'b0, 2);
        wait_resp();
        check_regs("write_fcsr", 5'h1A, 3'b010);
    endtask

    task automatic test_busy();
        fpu_busy = 1'b1;
        issue(mk(12'h001, 5'd1, 3'b010, 7'h73), 32'h0, 32'h0000_001E, 1'b0, 7);
        flag_valid = 2'b01;
        flags      = {5'h00, 5'h04};
        @(posedge clk); #1;
        flag_valid = 2'b00;
        flags      = '0;
        n_checks += 2;
        if (csr_ready_o !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b required 0", csr_ready_o); end
        if (csr_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL busy_rvalid: got %b required 0", csr_rvalid_o); end
        repeat (4) @(posedge clk);
        #1;
        fpu_busy = 1'b0;
        wait_resp();
        check_regs("busy", 5'h1E, 3'b010);
    endtask

    task automatic test_accrual_commit();
        issue(mk(12'h001, 5'd1, 3'b101, 7'h73), 32'h0, 32'h0000_001E, 1'b0, 2);
        wait_resp();
        check_regs("accrual_pre", 5'h01, 3'b010);
        issue(mk(12'h001, 5'd1, 3'b111, 7'h73), 32'h0, 32'h0000_0001, 1'b0, 2);
        flag_valid = 2'b11;
        flags      = {5'h10, 5'h01};
        @(posedge clk); #1;
        flag_valid = 2'b00;
        flags      = '0;
        wait_resp();
        check_regs("accrual_commit", 5'h11, 3'b010);
        flags = 10'h3FF;
        @(posedge clk); #1;
        check_regs("accrual_novalid", 5'h11, 3'b010);
        flag_valid = 2'b10;
        flags      = {5'h00, 5'h0E};
        @(posedge clk); #1;
        flag_valid = 2'b00;
        flags      = '0;
        check_regs("accrual_ch1", 5'h11, 3'b010);
    endtask

    task automatic check_rm(input logic [2:0] rm, input logic [2:0] ef, input logic ei);
        instr_rm = rm;
        #1;
        n_checks += 2;
        if (frm_o !== ef) begin n_fail++; $display("FAIL rm_%b_frm: got %b required %b", rm, frm_o, ef); end
        if (rm_illegal_o !== ei) begin n_fail++; $display("FAIL rm_%b_illegal: got %b required %b", rm, rm_illegal_o, ei); end
    endtask

    task automatic test_frm();
        issue(mk(12'h002, 5'd4, 3'b101, 7'h73), 32'h0, 32'h0000_0002, 1'b0, 2);
        wait_resp();
        check_regs("frm_wr4", 5'h11, 3'b100);
        check_rm(3'b111, 3'b100, 1'b0);
        check_rm(3'b001, 3'b001, 1'b0);
        check_rm(3'b110, 3'b110, 1'b1);
        issue(mk(12'h002, 5'h1D, 3'b101, 7'h73), 32'h0, 32'h0000_0004, 1'b0, 2);
        wait_resp();
        check_regs("frm_wr_wide", 5'h11, 3'b101);
        check_rm(3'b111, 3'b101, 1'b1);
        check_rm(3'b011, 3'b011, 1'b0);
        instr_rm = 3'b000;
    endtask

    task automatic test_illegal();
        issue(mk(12'h300, 5'd3, 3'b001, 7'h73), 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
        wait_resp();
        check_regs("illegal_addr", 5'h11, 3'b101);
        issue(mk(12'h003, 5'd3, 3'b100, 7'h73), 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
        issue(mk(12'h001, 5'd3, 3'b001, 7'h53), 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
        wait_resp();
        check_regs("illegal_op", 5'h11, 3'b101);
    endtask

    task automatic test_back_to_back();
        issue(mk(12'h003, 5'd0, 3'b010, 7'h73), 32'h0, 32'h0000_00B1, 1'b0, 2);
        issue(mk(12'h003, 5'd0, 3'b110, 7'h73), 32'h0, 32'h0000_00B1, 1'b0, 2);
        issue(mk(12'h003, 5'd2, 3'b010, 7'h73), 32'h0000_0102, 32'h0000_00B1, 1'b0, 2);
        issue(mk(12'h003, 5'd2, 3'b011, 7'h73), 32'h0000_00E0, 32'h0000_00B3, 1'b0, 2);
        wait_resp();
        check_regs("back_to_back", 5'h13, 3'b000);
    endtask

    task automatic test_reset_mid();
        fpu_busy = 1'b1;
        issue(mk(12'h001, 5'd1, 3'b001, 7'h73), 32'h0000_001F, 32'h0, 1'b0, 0);
        if (sb.size() != 0) void'(sb.pop_back());
        @(posedge clk); #1;
        rst_l = 1'b0;
        #2;
        fpu_busy = 1'b0;
        @(posedge clk); #1;
        rst_l = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_regs("reset_mid", 5'h00, RFRM);
        n_checks++;
        if (csr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b required 1", csr_ready_o); end
    endtask

    initial begin
        rst_l      = 1'b0;
        csr_valid  = 1'b0;
        csr_instr  = 32'd0;
        csr_rs1    = 32'd0;
        fpu_busy   = 1'b0;
        flag_valid = '0;
        flags      = '0;
        instr_rm   = 3'b000;
`ifdef FP_CSR_FS_DIRTY_EN
        fs_clean   = 1'b0;
`endif
        test_reset();
        test_read_x0();
        test_write_fcsr();
        test_busy();
        test_accrual_commit();
        test_frm();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_csr_ctrl.md
FP_CSR_CTRL -- requirements
Module: fp_csr_ctrl

Interface
REQ-001 Parameter NUM_FLAG_PORTS, default 2: number of FPU result channels reporting exception flags.
REQ-002 Parameter RESET_FRM, default 3'b000: frm value loaded at reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_l  in  1  reset, asynchronous assert, active-low.
REQ-005 csr_valid_i  in  1  CSR instruction offered.
REQ-006 csr_ready_o  out  1  block accepts instruction; transfer when valid&ready.
REQ-007 csr_instr_i  in  32  full instruction: addr[31:20], rs1/uimm[19:15], funct3[14:12], opcode[6:0].
REQ-008 csr_rs1_i  in  32  rs1 register value.
REQ-009 csr_rvalid_o  out  1  one-cycle response strobe.
REQ-010 csr_rdata_o  out  32  old CSR value, zero-extended; valid with csr_rvalid_o.
REQ-011 csr_illegal_o  out  1  illegal flag; valid with csr_rvalid_o.
REQ-012 fpu_busy_i  in  1  FP operations outstanding.
REQ-013 fpu_flag_valid_i  in  NUM_FLAG_PORTS  per-channel flag strobe.
REQ-014 fpu_flags_i  in  5*NUM_FLAG_PORTS  per-channel NV,DZ,OF,UF,NX; channel k at [5k+4:5k].
REQ-015 instr_rm_i  in  3  rm field of the current FP op.
REQ-016 frm_o  out  3  effective rounding mode; rm_illegal_o  out  1  effective mode reserved.
REQ-017 fflags_q_o  out  5 and frm_q_o  out  3: architectural register contents.

Function
REQ-018 Decode: opcode 7'h73; funct3 001/010/011 = RW/RS/RC with rs1 value; 101/110/111 = RWI/RSI/RCI with zero-extended uimm.
REQ-019 Addresses: 0x001 fflags[4:0], 0x002 frm[2:0], 0x003 fcsr={frm,fflags}; write bits above the CSR width are ignored.
REQ-020 Illegal: wrong opcode, funct3 000/100, or other address -> csr_illegal_o=1, rdata=0, no state change.
REQ-021 RS/RC/RSI/RCI with rs1 field 0 perform no write; RW/RWI always write.
REQ-022 FSM IDLE/WAIT/RESP; csr_ready_o=1 only in IDLE; accept moves IDLE->WAIT.
REQ-023 WAIT holds while fpu_busy_i=1; on first edge with fpu_busy_i=0 the write commits, old value latches into csr_rdata_o, state->RESP.
REQ-024 RESP: csr_rvalid_o=1 for exactly one cycle, then IDLE; minimum accept-to-rvalid latency 2 cycles.
REQ-025 Flag accrual every cycle: fflags |= OR of fpu_flags_i channels whose valid bit is 1.
REQ-026 Commit and accrual on same edge: fflags = written value | accrued flags.
REQ-027 frm_o = frm register when instr_rm_i=3'b111, else instr_rm_i; rm_illegal_o=1 when frm_o is 101, 110 or 111; combinational.
REQ-028 Outputs csr_rdata_o, csr_illegal_o, csr_rvalid_o are registered and hold 0 outside RESP.

Reset
REQ-029 rst_l low asynchronously forces: fflags=0, frm=RESET_FRM, state IDLE, csr_rvalid_o=0, csr_rdata_o=0, csr_illegal_o=0.
REQ-030 Reset during WAIT or RESP abandons the instruction; no write, no response after release.

Configuration
REQ-031 Macro FP_CSR_FS_DIRTY_EN defined: adds fs_clean_i (in,1) and fs_dirty_o (out,1); fs_dirty_o sets on any committed write or nonzero accrual, clears on fs_clean_i (set wins on same edge), resets to 0.
REQ-032 Macro undefined: both ports and the dirty state are absent; all other behaviour identical.

Verification
REQ-033 Reset release, CSRRS x0 of 0x003 -> rvalid 2 cycles after accept, rdata=0x00000000|RESET_FRM<<5, no write.
REQ-034 CSRRW 0x003 with rs1=0xFFFFFF5A -> rdata old value; then fflags_q_o=5'h1A, frm_q_o=3'b010.
REQ-035 fpu_busy_i high 5 cycles after accept -> ready 0, rvalid exactly once after busy falls, rdata reflects flags accrued meanwhile.
REQ-036 Channel0 flags 5'h01 and channel1 5'h10 same cycle while CSRRCI 0x001 uimm=0x01 commits -> fflags=5'h10|5'h01 rule per REQ-026 yields 5'h11 from written value 5'h00 plus accrual.
REQ-037 frm=3'b100, instr_rm_i=3'b111 -> frm_o=3'b100, rm_illegal_o=0; frm=3'b101 -> rm_illegal_o=1.
REQ-038 CSRRW to address 0x300 -> csr_illegal_o=1, rdata=0, fflags/frm unchanged.
